// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the dual-clock FIFO: binary/Gray pointer conversion.
// The functions work on a fixed 32-bit container. Callers zero-extend a
// narrower pointer into it and cast the result back. Because the unused upper
// bits are zero, both conversions give the same result as a native-width
// conversion for any pointer width up to PTR_MAX_W.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Binary to reflected Gray: adjacent values differ in exactly one bit.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/param_async_fifo_if.sv
// -----------------------------------------------------------------------------
// param_async_fifo_if
// Handshake and status bundle of the dual-clock FIFO. Clocks and reset are
// not part of the bundle; they stay as plain ports on the FIFO.
//   master : the producer/consumer side (drives wr_en, wr_data, rd_en)
//   slave  : the FIFO side (drives data out, flags, counts, error pulses)
// -----------------------------------------------------------------------------
interface param_async_fifo_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    // write domain
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_count;
    logic              overflow;
    // read domain
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_count;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, wr_count, overflow,
        input  rd_data, rd_valid, empty, almost_empty, rd_count, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, wr_count, overflow,
        output rd_data, rd_valid, empty, almost_empty, rd_count, underflow
    );

endinterface

// File: rtl/gray_sync.sv
// -----------------------------------------------------------------------------
// gray_sync
// Multi-flop synchronizer that carries a Gray-coded pointer into the clk
// domain. Only one bit of the input changes per source update, so each stage
// samples either the old or the new pointer value and never a mix of the two.
//   clk   : destination-domain clock
//   reset : asynchronous, active-high clear of all stages
//   d     : Gray pointer, registered in the source domain
//   q     : synchronized Gray pointer, STAGES clk edges behind d
// -----------------------------------------------------------------------------
module gray_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_q [STAGES];

    // NOTE: sequential state is updated with non-blocking assignments, so every
    // stage samples the value its predecessor held before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/param_async_fifo.sv
// -----------------------------------------------------------------------------
// param_async_fifo
// Dual-clock FIFO that carries WIDTH-bit words from wr_clk to rd_clk.
// The FIFO holds DEPTH = 2**ADDR_W words.
// Each domain owns a binary pointer of ADDR_W+1 bits. The MSB is the wrap bit.
// Each pointer also has a registered Gray copy, and only the Gray copy crosses
// into the other domain, through a gray_sync.
//   wr_clk, rd_clk : write / read domain clocks
//   reset          : asynchronous, active-high; clears both domains at once
//   bus (slave)    : write side  wr_en, wr_data -> full, almost_full,
//                                 wr_count, overflow
//                    read side   rd_en -> rd_data, rd_valid, empty,
//                                 almost_empty, rd_count, underflow
// full/empty are derived from a delayed view of the far pointer. They can
// therefore stay asserted longer than strictly needed, but they never release
// early. rd_data and rd_valid are registered and follow an accepted read by
// one rd_clk edge.
// -----------------------------------------------------------------------------
module param_async_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ADDR_W        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AFULL_THRESH  = (1 << ADDR_W) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 wr_clk,
    input  logic                 rd_clk,
    input  logic                 reset,
    param_async_fifo_if.slave    bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t AFULL_LVL  = ptr_t'(AFULL_THRESH);
    localparam ptr_t AEMPTY_LVL = ptr_t'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------ write
    ptr_t wr_bin, wr_bin_next, wr_gray;
    ptr_t rq, rq_bin;              // read Gray pointer as seen in wr_clk domain
    ptr_t wr_count;
    logic full, wr_accept, overflow;

    assign wr_accept   = bus.wr_en && !full;
    assign wr_bin_next = wr_bin + ptr_t'(wr_accept);

    // The Gray copy is a register, not a decode of wr_bin. A decode could glitch
    // through several codes during an update, and the synchronizer could sample
    // one of those codes.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            wr_bin   <= '0;
            wr_gray  <= '0;
            overflow <= 1'b0;
        end else begin
            wr_bin   <= wr_bin_next;
            wr_gray  <= ptr_t'(bin2gray(ptr_word_t'(wr_bin_next)));
            overflow <= bus.wr_en && full;
        end
    end

    // NOTE: the storage array has no reset. A word is only read after its write
    // has crossed into the read domain, so the initial contents are never seen.
    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem[wr_bin[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    gray_sync #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_rd2wr_sync (
        .clk   (wr_clk),
        .reset (reset),
        .d     (rd_gray),
        .q     (rq)
    );

    // Full: the writer is exactly one lap ahead of the reader. In Gray code
    // that is equality with the top two bits of the far pointer inverted.
    assign full     = (wr_gray == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
    assign rq_bin   = ptr_t'(gray2bin(ptr_word_t'(rq)));
    assign wr_count = wr_bin - rq_bin;

    assign bus.full        = full;
    assign bus.wr_count    = wr_count;
    assign bus.almost_full = (wr_count >= AFULL_LVL);
    assign bus.overflow    = overflow;

    // ------------------------------------------------------------------- read
    ptr_t rd_bin, rd_bin_next, rd_gray;
    ptr_t wq, wq_bin;              // write Gray pointer as seen in rd_clk domain
    ptr_t rd_count;
    logic empty, rd_accept, underflow, rd_valid;
    logic [WIDTH-1:0] rd_data;

    assign rd_accept   = bus.rd_en && !empty;
    assign rd_bin_next = rd_bin + ptr_t'(rd_accept);

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            rd_bin    <= '0;
            rd_gray   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_bin    <= rd_bin_next;
            rd_gray   <= ptr_t'(bin2gray(ptr_word_t'(rd_bin_next)));
            rd_valid  <= rd_accept;
            underflow <= bus.rd_en && empty;
            if (rd_accept) begin
                rd_data <= mem[rd_bin[ADDR_W-1:0]];
            end
        end
    end

    gray_sync #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_wr2rd_sync (
        .clk   (rd_clk),
        .reset (reset),
        .d     (wr_gray),
        .q     (wq)
    );

    assign empty    = (rd_gray == wq);
    assign wq_bin   = ptr_t'(gray2bin(ptr_word_t'(wq)));
    assign rd_count = wq_bin - rd_bin;

    assign bus.empty        = empty;
    assign bus.rd_count     = rd_count;
    assign bus.almost_empty = (rd_count <= AEMPTY_LVL);
    assign bus.rd_data      = rd_data;
    assign bus.rd_valid     = rd_valid;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_param_async_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_param_async_fifo
// Scoreboard bench for param_async_fifo. Every write that the bench issues
// while the FIFO is not full pushes its word onto exp_q. The read monitor pops
// one word from exp_q for each rd_valid and compares it with rd_data.
// -----------------------------------------------------------------------------
module tb_param_async_fifo;

    localparam int WIDTH       = 8;
    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 1 << ADDR_W;

    logic    wr_clk = 1'b0;
    logic    rd_clk = 1'b0;
    logic    reset  = 1'b0;
    realtime wr_half = 5.0;    // 100 MHz
    realtime rd_half = 13.5;   // ~37 MHz

    always #(wr_half) wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    param_async_fifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    param_async_fifo #(
        .WIDTH       (WIDTH),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .wr_clk (wr_clk),
        .rd_clk (rd_clk),
        .reset  (reset),
        .bus    (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int ovf_cnt   = 0;
    int udf_cnt   = 0;
    int max_rd_count = 0;
    logic [WIDTH-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read-side monitor: scoreboard compare plus bookkeeping.
    always @(posedge rd_clk) begin
        #1;
        if (bus.rd_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) check("rd_unexpected", 32'(bus.rd_data), 32'hFFFF_FFFF);
            else                   check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
        if (int'(bus.rd_count) > max_rd_count) max_rd_count = int'(bus.rd_count);
        if (bus.underflow === 1'b1) udf_cnt++;
    end

    always @(posedge wr_clk) begin
        #1;
        if (bus.overflow === 1'b1) ovf_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr_cycle();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic rd_cycle();
        @(posedge rd_clk);
        #1;
    endtask

    // Producer: n words, each accepted write pushed to the scoreboard.
    task automatic produce(input int n, input int max_occ, input bit rnd);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            wr_cycle();
            guard++;
            if (!bus.full && int'(bus.wr_count) < max_occ &&
                (!rnd || $urandom_range(1, 0) == 1)) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'($urandom);
                exp_q.push_back(bus.wr_data);
                sent++;
            end else begin
                bus.wr_en = 1'b0;
            end
        end
        wr_cycle();
        bus.wr_en = 1'b0;
        check("produce_done", sent, n);
    endtask

    task automatic consume(input int n, input bit rnd);
        int got   = 0;
        int guard = 0;
        while (got < n && guard < 20000) begin
            rd_cycle();
            guard++;
            if (!bus.empty && (!rnd || $urandom_range(1, 0) == 1)) begin
                bus.rd_en = 1'b1;
                got++;
            end else begin
                bus.rd_en = 1'b0;
            end
        end
        rd_cycle();
        bus.rd_en = 1'b0;
        check("consume_done", got, n);
    endtask

    // Read until the scoreboard is empty; a leftover entry is a failure.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.rd_valid) && n < budget) begin
            bus.rd_en = !bus.empty;
            rd_cycle();
            n++;
        end
        bus.rd_en = 1'b0;
        rd_cycle();
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int edges;
        int v0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;

        // ---- reset values
        #1 reset = 1'b1;
        #2;
        check("rst_full",         32'(bus.full),         0);
        check("rst_almost_full",  32'(bus.almost_full),  0);
        check("rst_wr_count",     32'(bus.wr_count),     0);
        check("rst_overflow",     32'(bus.overflow),     0);
        check("rst_rd_data",      32'(bus.rd_data),      0);
        check("rst_rd_valid",     32'(bus.rd_valid),     0);
        check("rst_empty",        32'(bus.empty),        1);
        check("rst_almost_empty", 32'(bus.almost_empty), 1);
        check("rst_rd_count",     32'(bus.rd_count),     0);
        check("rst_underflow",    32'(bus.underflow),    0);
        repeat (2) rd_cycle();
        reset = 1'b0;
        repeat (SYNC_STAGES + 1) rd_cycle();

        // ---- fill to full with 0x10..0x1F, no reads
        wr_cycle();
        for (int k = 0; k < DEPTH; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h10 + k);
            exp_q.push_back(bus.wr_data);
            wr_cycle();
            check("fill_wr_count",    32'(bus.wr_count),    32'(k + 1));
            check("fill_almost_full", 32'(bus.almost_full), 32'((k + 1) >= DEPTH - 2));
        end
        check("fill_full", 32'(bus.full), 1);
        bus.wr_data = 8'hEE;                       // 17th request, must be dropped
        wr_cycle();
        check("ovf_pulse",    32'(bus.overflow), 1);
        check("ovf_wr_count", 32'(bus.wr_count), DEPTH);
        bus.wr_en = 1'b0;
        wr_cycle();
        check("ovf_clear", 32'(bus.overflow), 0);
        repeat (SYNC_STAGES + 2) rd_cycle();
        check("fill_rd_count",     32'(bus.rd_count),     DEPTH);
        check("fill_empty",        32'(bus.empty),        0);
        check("fill_almost_empty", 32'(bus.almost_empty), 0);

        // ---- drain at 100/37 MHz
        valid_cnt = 0;
        drain("drain_sb_empty", 400);
        check("drain_valid_cnt", valid_cnt, DEPTH);
        check("drain_empty",     32'(bus.empty),    1);
        check("drain_rd_count",  32'(bus.rd_count), 0);
        bus.rd_en = 1'b1;                          // read while empty
        rd_cycle();
        check("udf_pulse",    32'(bus.underflow), 1);
        check("udf_rd_valid", 32'(bus.rd_valid),  0);
        check("udf_rd_hold",  32'(bus.rd_data),   32'h1F);
        bus.rd_en = 1'b0;
        rd_cycle();
        check("udf_clear", 32'(bus.underflow), 0);
        repeat (SYNC_STAGES + 3) wr_cycle();
        check("drain_full",     32'(bus.full),     0);
        check("drain_wr_count", 32'(bus.wr_count), 0);

        // ---- random streaming, writer 3x faster then reader 3x faster
        for (int r = 0; r < 2; r++) begin
            wr_half = (r == 0) ? 5.0 : 15.0;
            rd_half = (r == 0) ? 15.0 : 5.0;
            repeat (4) rd_cycle();
            ovf_cnt = 0;
            udf_cnt = 0;
            fork
                produce(500, DEPTH + 1, 1'b1);
                consume(500, 1'b1);
            join
            drain("stream_sb_empty", 200);
            check("stream_no_overflow",  ovf_cnt, 0);
            check("stream_no_underflow", udf_cnt, 0);
        end

        // ---- low-occupancy run across several pointer wraps
        wr_half = 5.0;
        rd_half = 13.5;
        repeat (4) rd_cycle();
        max_rd_count = 0;
        fork
            produce(40, 3, 1'b0);
            consume(40, 1'b0);
        join
        drain("wrap_sb_empty", 200);
        check("wrap_rd_count_le3", 32'(max_rd_count <= 3), 1);

        // ---- single write into an empty FIFO: empty release latency
        repeat (4) rd_cycle();
        wr_cycle();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h5A;
        exp_q.push_back(8'h5A);
        @(posedge wr_clk);
        fork
            begin #1 bus.wr_en = 1'b0; end
        join_none
        edges = 0;
        while (edges < 8) begin
            @(posedge rd_clk);
            #0.5;
            edges++;
            if (!bus.empty) break;
        end
        check("empty_fall_window",
              32'(edges >= SYNC_STAGES && edges <= SYNC_STAGES + 1), 1);
        drain("latency_sb_empty", 100);

        // ---- reset with 9 words queued
        wr_cycle();
        for (int k = 0; k < 9; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h60 + k);
            exp_q.push_back(bus.wr_data);
            wr_cycle();
        end
        bus.wr_en = 1'b0;
        repeat (SYNC_STAGES + 3) rd_cycle();
        check("pre_rst_rd_count", 32'(bus.rd_count), 9);
        @(posedge wr_clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_empty",    32'(bus.empty),    1);
        check("mid_rst_full",     32'(bus.full),     0);
        check("mid_rst_wr_count", 32'(bus.wr_count), 0);
        check("mid_rst_rd_count", 32'(bus.rd_count), 0);
        check("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
        repeat (2) wr_cycle();
        reset = 1'b0;
        repeat (SYNC_STAGES + 1) rd_cycle();
        wr_cycle();
        v0 = valid_cnt;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        wr_cycle();
        bus.wr_en = 1'b0;
        drain("post_rst_sb_empty", 100);
        check("post_rst_one_word", valid_cnt - v0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_async_fifo.md
# param_async_fifo

Parametrised dual-clock FIFO that carries WIDTH-bit words from the wr_clk domain to the rd_clk domain, with explicit write/read enables, per-domain fill counts, programmable almost-full/almost-empty flags and overflow/underflow reporting. It is the general-purpose clock-domain-crossing buffer for the datapath and replaces fixed 8-bit/16-deep FIFO instances. Gray-coded pointers cross domains through a configurable-depth synchronizer.

## Interface
- WIDTH, 8, data word width (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W (ADDR_W ≥ 2)
- SYNC_STAGES, 2, synchronizer flops per crossing (≥2)
- AFULL_THRESH, DEPTH-2, almost_full asserts when wr_count ≥ this
- AEMPTY_THRESH, 2, almost_empty asserts when rd_count ≤ this
- wr_clk  in  1  write-domain clock
- rd_clk  in  1  read-domain clock
- reset  in  1  reset, asynchronous, active-high; clock wr_clk (also asynchronously clears all rd_clk-domain state)
- wr_en  in  1  write request
- wr_data  in  WIDTH  write word
- full  out  1  no space (write domain)
- almost_full  out  1  wr_count ≥ AFULL_THRESH
- wr_count  out  ADDR_W+1  occupancy seen by writer (0..DEPTH)
- overflow  out  1  one-cycle pulse: wr_en while full
- rd_en  in  1  read request
- rd_data  out  WIDTH  registered read word
- rd_valid  out  1  rd_data holds a newly read word this cycle
- empty  out  1  no data (read domain)
- almost_empty  out  1  rd_count ≤ AEMPTY_THRESH
- rd_count  out  ADDR_W+1  occupancy seen by reader
- underflow  out  1  one-cycle pulse: rd_en while empty

## Operation
- Pointers: binary wr_bin/rd_bin of ADDR_W+1 bits; MSB is wrap bit. Gray copies are registered (never combinational) before crossing.
- Write accepted iff wr_en && !full: mem[wr_bin[ADDR_W-1:0]] ← wr_data, wr_bin += 1. wr_en && full: no write, no pointer change, overflow = 1 next cycle.
- Read accepted iff rd_en && !empty: rd_data ← mem[rd_bin[ADDR_W-1:0]], rd_valid = 1 next cycle, rd_bin += 1. rd_en && empty: rd_data holds, rd_valid = 0, underflow = 1 next cycle.
- full = (wr_gray == {~rq[A:A-1], rq[A-2:0]}) on synchronized read Gray pointer rq; empty = (rd_gray == synchronized write Gray pointer).
- Counts: wr_count = wr_bin − gray2bin(rq); rd_count = gray2bin(wq) − rd_bin; modulo 2**(ADDR_W+1).
- Flags are conservative: full/empty may stay asserted longer than true, never deassert early. No data loss or duplication under any clock ratio.
- Pointer wrap (DEPTH, 2*DEPTH transitions) is seamless; no special case.

## Timing
- Reset values: full 0, almost_full 0 (unless AFULL_THRESH = 0), wr_count 0, overflow 0, rd_data 0, rd_valid 0, empty 1, almost_empty 1, rd_count 0, underflow 0; all pointers and sync flops 0. Memory contents not reset.
- Reset assertion clears both domains immediately; after deassertion, inputs ignored by the environment for SYNC_STAGES+1 cycles of the slower clock.
- Reset mid-transfer discards all contents; no partial outputs afterwards.
- Write→empty deassert: SYNC_STAGES rd_clk edges after the wr_clk edge that registers wr_gray (+≤1 rd_clk sampling uncertainty).
- Read→full deassert: SYNC_STAGES wr_clk edges after the rd_clk edge that registers rd_gray (+≤1).
- Read latency: 1 rd_clk; rd_data/rd_valid valid the edge after acceptance.
- full, empty, counts, almost flags: combinational from registered pointers/sync outputs; overflow/underflow registered.
- Simultaneous read and write of same slot is impossible (empty/full guard); simultaneous write at full and read in other domain: write rejected, retried by producer.

## Structure
- Shared package fifo_pkg: bin2gray and gray2bin functions parametrised on width; typedef for pointer width not required (width derived from ADDR_W).
- Sub-module gray_sync: SYNC_STAGES-deep, (ADDR_W+1)-bit synchronizer with async reset, instantiated once per direction.
- Memory: plain register array, synchronous write on wr_clk, registered read on rd_clk.

## Test plan
- Reset, then 16 writes (0x10..0x1F, WIDTH=8, ADDR_W=4) with rd_en=0 -> full=1 after 16th, wr_count=16, almost_full from count 14; 17th wr_en -> overflow pulse, contents unchanged.
- Drain all 16 with wr_clk 100 MHz / rd_clk 37 MHz -> rd_data 0x10..0x1F in order, rd_valid 16 cycles total, empty=1 at end; extra rd_en -> underflow pulse, rd_valid 0.
- Continuous streaming 1000 words, random wr_en/rd_en, both clock ratios (3:1 and 1:3) -> scoreboard exact match, no overflow/underflow when enables gated by flags.
- Pointer wrap: push/pop 40 words at occupancy ≤3 -> correct order across wrap, rd_count never > DEPTH.
- Single write to empty FIFO -> empty falls exactly SYNC_STAGES (±1) rd_clk edges later; SYNC_STAGES=3 build adds one edge.
- Assert reset with 9 words queued -> empty=1, full=0, counts 0, rd_valid 0 immediately; subsequent write of 0xA5 reads back 0xA5.
